// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the system-bus arbiter: default bus widths, FSM state
// encodings, master index constants and the latency-counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Default bus widths
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Master index assignment on the shared bus
    localparam int MST_IFU = 0;   // instruction fetch
    localparam int MST_LSU = 1;   // load/store
    localparam int MST_DBG = 2;   // debug

    // Latency counter holds 0..15
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles the master-side request/response signals and the interconnect-side
// bus signals of the arbiter.
//   slave  modport : arbiter view (requests and busReadData in; grants,
//                    completions, read data and bus drive out)
//   master modport : environment view (masters plus interconnect)
// Signals:
//   mReq, mWriteEnable [NUM_MASTERS]       per-master request / write flag
//   mAddr  [NUM_MASTERS*ADDR_W]            packed, master i at [i*ADDR_W +: ADDR_W]
//   mWriteData [NUM_MASTERS*DATA_W]        packed write data
//   mGnt, mDone [NUM_MASTERS]              one-cycle pulses
//   mReadData [DATA_W]                     captured read data
//   busWriteEnable, busAddr, busWriteData  towards interconnect
//   busReadData [DATA_W]                   from interconnect
// -----------------------------------------------------------------------------
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = MST_DBG + 1,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
);
    logic [NUM_MASTERS-1:0]        mReq;
    logic [NUM_MASTERS-1:0]        mWriteEnable;
    logic [NUM_MASTERS*ADDR_W-1:0] mAddr;
    logic [NUM_MASTERS*DATA_W-1:0] mWriteData;
    logic [NUM_MASTERS-1:0]        mGnt;
    logic [NUM_MASTERS-1:0]        mDone;
    logic [DATA_W-1:0]             mReadData;
    logic                          busWriteEnable;
    logic [ADDR_W-1:0]             busAddr;
    logic [DATA_W-1:0]             busWriteData;
    logic [DATA_W-1:0]             busReadData;

    modport slave (
        input  mReq, mWriteEnable, mAddr, mWriteData, busReadData,
        output mGnt, mDone, mReadData, busWriteEnable, busAddr, busWriteData
    );

    modport master (
        output mReq, mWriteEnable, mAddr, mWriteData, busReadData,
        input  mGnt, mDone, mReadData, busWriteEnable, busAddr, busWriteData
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector. Searches req_i starting at
// (last_i+1) mod N, wrapping, and returns the first requester found.
// Ports:
//   req_i  [N]      request vector
//   last_i [IDX_W]  index of the previous winner
//   gnt_o  [N]      one-hot winner (all zero when no request)
//   idx_o  [IDX_W]  winner index (0 when no request)
// -----------------------------------------------------------------------------
module rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int N     = MST_DBG + 1,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    // Offsets 1..N visit every master once, ending on last_i itself, so the
    // previous winner only wins again when nobody else is asking.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_i[(int'(last_i) + k) % N]) begin
                found                          = 1'b1;
                gnt_o[(int'(last_i) + k) % N]  = 1'b1;
                idx_o                          = IDX_W'((int'(last_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the single system bus between NUM_MASTERS requesters (0 = fetch,
// 1 = load/store, 2 = debug) with round-robin fairness. A winning request is
// latched, driven onto the bus for RD_LATENCY+1 cycles, the slave read data is
// captured after the fixed latency and returned with a mDone pulse.
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   bif        bus_arbiter_if.slave (master requests, grants/completions,
//              shared read data, interconnect drive and read data)
//   perfClear  (BUS_ARB_PERF_EN only) synchronous clear of grant counters
//   grantCount (BUS_ARB_PERF_EN only) NUM_MASTERS x 32-bit grant counters,
//              master i at [i*32 +: 32]
// Optional feature macro: BUS_ARB_PERF_EN (per-master grant counters).
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = MST_DBG + 1,
    parameter int RD_LATENCY  = 1,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rstn,
`ifdef BUS_ARB_PERF_EN
    input  logic                      perfClear,
    output logic [NUM_MASTERS*32-1:0] grantCount,
`endif
    bus_arbiter_if.slave              bif
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RD_LATENCY);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;

    logic [NUM_MASTERS-1:0] gnt_c, done_c;
    logic                   bwe_c;
    logic [ADDR_W-1:0]      baddr_c;
    logic [DATA_W-1:0]      bwdata_c;

    rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (bif.mReq),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lat_q   <= lat_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lat_d    = lat_q;
        rdata_d  = rdata_q;
        gnt_c    = '0;
        done_c   = '0;
        bwe_c    = 1'b0;
        baddr_c  = '0;
        bwdata_c = '0;

        case (state_q)
            IDLE: begin
                if (|pick_gnt) begin
                    we_d    = bif.mWriteEnable[pick_idx];
                    addr_d  = bif.mAddr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = bif.mWriteData[pick_idx*DATA_W +: DATA_W];
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    lat_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                baddr_c  = addr_q;
                bwdata_c = wdata_q;
                // lat_q is zero only on the first BUSY cycle: grant pulse and
                // the single write strobe both live there.
                if (lat_q == '0) begin
                    gnt_c[owner_q] = 1'b1;
                    bwe_c          = we_q;
                end
                // Writes capture too; the value is simply unused by the master.
                if (lat_q == LAT_END) begin
                    rdata_d = bif.busReadData;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            RESP: begin
                done_c[owner_q] = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bif.mGnt           = gnt_c;
    assign bif.mDone          = done_c;
    assign bif.mReadData      = rdata_q;
    assign bif.busWriteEnable = bwe_c;
    assign bif.busAddr        = baddr_c;
    assign bif.busWriteData   = bwdata_c;

`ifdef BUS_ARB_PERF_EN
    // ------------------------------------------------------ grant counters
    logic [NUM_MASTERS-1:0][31:0] cnt_q, cnt_d;

    // Clear wins over a coincident grant.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (perfClear)     cnt_d[i] = '0;
            else if (gnt_c[i]) cnt_d[i] = cnt_q[i] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign grantCount = cnt_q;
`endif

endmodule
